div_unit: RTL and testbench

- Multi-cycle iterative 32-bit divider, signed and unsigned, for the MIPS execute stage.
- Produces the 64-bit div_result / diven pair consumed by the HI/LO register: {remainder, quotient}, remainder destined for HI and quotient for LO.
- Raises busy so the pipeline stalls while a division is in flight.

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit.sv | 110 +++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// ============================================================================
// div_unit_pkg : shared divider defines (state codes, ALU control codes)
// Rev 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'b00;
  localparam div_state_t DIV_BUSY = 2'b01;
  localparam div_state_t DIV_DONE = 2'b10;

  // Execute-stage control codes; divide codes sit beside the multiply/move ones
  localparam logic [7:0] MULT_CONTROL  = 8'b0001_1000;
  localparam logic [7:0] MULTU_CONTROL = 8'b0001_1001;
  localparam logic [7:0] DIV_CONTROL   = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL  = 8'b0001_1011;
  localparam logic [7:0] MTHI_CONTROL  = 8'b0001_0001;
  localparam logic [7:0] MTLO_CONTROL  = 8'b0001_0011;

  localparam int DIV_ITERS = 32;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : multi-cycle restoring divider, signed/unsigned, {rem, quo} result
// Rev 1.0
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;   // dividend bits shift out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;

  always_comb begin
    w_trial    = {r_rem, r_dvd[WIDTH-1]};
    w_diff     = w_trial - {1'b0, r_dvs};
    w_qbit     = ~w_diff[WIDTH];
    // On restore the trial is below the divisor, so its top bit is already zero
    w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};
    w_quo_fin  = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    w_rem_fin  = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    w_abs1     = opdata1[WIDTH-1] ? (~opdata1 + 1'b1) : opdata1;
    w_abs2     = opdata2[WIDTH-1] ? (~opdata2 + 1'b1) : opdata2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      result  <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            if (opdata2 == '0) begin
              result  <= {opdata1, {WIDTH{1'b1}}};
              r_state <= DIV_DONE;
            end else begin
              r_dvd   <= signed_div ? w_abs1 : opdata1;
              r_dvs   <= signed_div ? w_abs2 : opdata2;
              r_neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
              r_neg_r <= signed_div & opdata1[WIDTH-1];
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (annul) begin
            r_state <= DIV_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last_iter) begin
              result  <= {w_rem_fin, w_quo_fin};
              r_state <= DIV_DONE;
            end
          end
        end
        DIV_DONE: r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == DIV_BUSY);
  assign ready = (r_state == DIV_DONE);

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : table, directed and randomized checks of div_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .busy       (busy),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain integer arithmetic
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input string name,
                        input logic ann_start, input logic mid_start);
    int cyc;
    int busy_err;
    int exp_lat;
    exp_lat = (b == 0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b; annul = ann_start;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    cyc = 1;
    busy_err = 0;
    while (!ready && cyc < 100) begin
      if (busy !== (b != 0 && cyc <= 32)) busy_err++;
      if (mid_start && cyc == 5) begin
        start = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
      end else if (mid_start && cyc == 6) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (busy !== 1'b0) busy_err++;
    chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({name, " result"}, result, exp);
    chk({name, " busy"}, 64'(busy_err), 64'd0);
    @(posedge clk); #1;
    chk({name, " ready_pulse"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, "u100_7"};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, "s-7_2"};
    vecs[2] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, "s7_-2"};
    vecs[3] = '{32'd5,         32'd0,         1'b0, 64'h00000005_FFFFFFFF, "div0u"};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, "ovf_s"};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, "ovf_u"};
    vecs[6] = '{32'hFFFF_FFF9, 32'd0,         1'b1, 64'hFFFFFFF9_FFFFFFFF, "div0s"};
    vecs[7] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 64'h00000000_FFFFFFFF, "umax_1"};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   {63'd0, busy},  64'd0);
    chk("reset ready",  {63'd0, ready}, 64'd0);
    chk("reset result", result,         64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].name, 1'b0, 1'b0);

    // Annul mid-flight: no ready, result keeps the previous value
    do_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, "pre_annul", 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul busy",   {63'd0, busy},  64'd0);
    chk("annul ready",  {63'd0, ready}, 64'd0);
    chk("annul result", result,         64'h00000000_00000003);
    @(posedge clk);
    do_div(32'd17, 32'd4, 1'b0, 64'h00000001_00000004, "post_annul", 1'b0, 1'b0);

    // annul together with start in IDLE: start wins
    do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "annul_start", 1'b1, 1'b0);
    // start pulsed while busy is ignored
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "start_in_busy", 1'b0, 1'b1);

    // Reset in the middle of a division
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy",   {63'd0, busy},  64'd0);
    chk("midrst ready",  {63'd0, ready}, 64'd0);
    chk("midrst result", result,         64'd0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = {16'd0, 16'($urandom)};
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", i), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
